// File: rtl/exe_wb_arbiter.sv
// Writeback collector: per-source result FIFOs (ALU/MUL/LSU) granted round-robin to one RF write port.
// Optional WB_BYPASS_EN lets a result skip its empty FIFO and retire with one-cycle latency.
module exe_wb_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int SKID       = 3,
   parameter int REG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [REG_WIDTH+33:0] alu_wb_inf,
   input  logic [REG_WIDTH+33:0] mul_wb_inf,
   input  logic [REG_WIDTH+33:0] lsu_wb_inf,
   output logic [2:0]            src_almost_full,
   output logic                  rf_we,
   output logic [REG_WIDTH-1:0]  rf_rd,
   output logic [31:0]           rf_data,
   output logic                  wb_retire,
   output logic                  overflow_err
);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int ENT_W = REG_WIDTH + 33;
   localparam int AF_TH = FIFO_DEPTH - SKID;

   logic [ENT_W-1:0]     mem_q [3][FIFO_DEPTH];
   logic [PW-1:0]        wp_q [3];
   logic [PW-1:0]        wp_d [3];
   logic [PW-1:0]        rp_q [3];
   logic [PW-1:0]        rp_d [3];
   logic [CW-1:0]        cnt_q [3];
   logic [CW-1:0]        cnt_d [3];
   logic [1:0]           rr_q, rr_d;
   logic [2:0]           af_q, af_d;
   logic                 we_q, we_d;
   logic                 ret_q, ret_d;
   logic                 ovf_q, ovf_d;
   logic [REG_WIDTH-1:0] rd_q, rd_d;
   logic [31:0]          data_q, data_d;

   logic [2:0]           vld_s;
   logic [ENT_W-1:0]     ent_s [3];
   logic [2:0]           cand_s, push_s, pop_s, want_s, full_s;
   logic                 accept_s, gnt_vld_s, byp_s, ovf_set_s;
   logic [1:0]           gnt_idx_s;
   logic [ENT_W-1:0]     gnt_ent_s;

   // Split each result bus into its valid bit and the stored {register_write, rd, exe_result}.
   always_comb begin
      vld_s    = {lsu_wb_inf[ENT_W], mul_wb_inf[ENT_W], alu_wb_inf[ENT_W]};
      ent_s[0] = alu_wb_inf[ENT_W-1:0];
      ent_s[1] = mul_wb_inf[ENT_W-1:0];
      ent_s[2] = lsu_wb_inf[ENT_W-1:0];
   end

   // Round-robin grant: first candidate at or after the RR pointer, then select its entry.
   always_comb begin
      accept_s  = ~stall & ~flush;
      cand_s    = 3'b000;
      gnt_vld_s = 1'b0;
      gnt_idx_s = 2'd0;
      byp_s     = 1'b0;
      gnt_ent_s = {ENT_W{1'b0}};
      for (int i = 0; i < 3; i++) begin
`ifdef WB_BYPASS_EN
         cand_s[i] = accept_s & ((cnt_q[i] != {CW{1'b0}}) | vld_s[i]);
`else
         cand_s[i] = accept_s & (cnt_q[i] != {CW{1'b0}});
`endif
      end
      for (int k = 0; k < 3; k++) begin
         if (!gnt_vld_s && cand_s[(int'(rr_q) + k) % 3]) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = 2'((int'(rr_q) + k) % 3);
         end else begin
            gnt_vld_s = gnt_vld_s;
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (gnt_vld_s && (gnt_idx_s == 2'(i))) begin
`ifdef WB_BYPASS_EN
            byp_s = (cnt_q[i] == {CW{1'b0}});
`endif
            gnt_ent_s = byp_s ? ent_s[i] : mem_q[i][rp_q[i]];
         end else begin
            gnt_ent_s = gnt_ent_s;
         end
      end
   end

   // FIFO pointer/count updates, overflow detection and next output values.
   always_comb begin
      ovf_set_s = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pop_s[i]  = gnt_vld_s & (gnt_idx_s == 2'(i)) & ~byp_s;
         full_s[i] = (cnt_q[i] == CW'(FIFO_DEPTH));
         want_s[i] = accept_s & vld_s[i] & ~(byp_s & (gnt_idx_s == 2'(i)));
         push_s[i] = want_s[i] & ~full_s[i];
         ovf_set_s = ovf_set_s | (want_s[i] & full_s[i]);
         if (flush) begin
            wp_d[i]  = {PW{1'b0}};
            rp_d[i]  = {PW{1'b0}};
            cnt_d[i] = {CW{1'b0}};
         end else begin
            wp_d[i]  = wp_q[i] + PW'(push_s[i]);
            rp_d[i]  = rp_q[i] + PW'(pop_s[i]);
            cnt_d[i] = cnt_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
         end
         af_d[i] = (int'(cnt_d[i]) >= AF_TH);
      end
      rr_d   = rr_q;
      we_d   = 1'b0;
      ret_d  = 1'b0;
      rd_d   = rd_q;
      data_d = data_q;
      if (gnt_vld_s) begin
         ret_d  = 1'b1;
         rd_d   = gnt_ent_s[REG_WIDTH+31:32];
         data_d = gnt_ent_s[31:0];
         we_d   = gnt_ent_s[ENT_W-1] & (gnt_ent_s[REG_WIDTH+31:32] != {REG_WIDTH{1'b0}});
         rr_d   = (gnt_idx_s == 2'd2) ? 2'd0 : gnt_idx_s + 2'd1;
      end else begin
         rr_d = rr_q;
      end
      ovf_d = ovf_q | ovf_set_s;
   end

   // State registers, FIFO storage and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            wp_q[i]  <= {PW{1'b0}};
            rp_q[i]  <= {PW{1'b0}};
            cnt_q[i] <= {CW{1'b0}};
            for (int j = 0; j < FIFO_DEPTH; j++) begin
               mem_q[i][j] <= {ENT_W{1'b0}};
            end
         end
         rr_q   <= 2'd0;
         af_q   <= 3'b000;
         we_q   <= 1'b0;
         ret_q  <= 1'b0;
         ovf_q  <= 1'b0;
         rd_q   <= {REG_WIDTH{1'b0}};
         data_q <= 32'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            wp_q[i]  <= wp_d[i];
            rp_q[i]  <= rp_d[i];
            cnt_q[i] <= cnt_d[i];
            if (push_s[i]) begin
               mem_q[i][wp_q[i]] <= ent_s[i];
            end
         end
         rr_q   <= rr_d;
         af_q   <= af_d;
         we_q   <= we_d;
         ret_q  <= ret_d;
         ovf_q  <= ovf_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign src_almost_full = af_q;
   assign rf_we           = we_q;
   assign rf_rd           = rd_q;
   assign rf_data         = data_q;
   assign wb_retire       = ret_q;
   assign overflow_err    = ovf_q;
endmodule
